// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and constants for the branch predictor
// Contents: pc_src_t next-PC select encoding, 2-bit counter constants,
//           btb_entry_t table entry layout and its reset value.
package branch_pkg;

  typedef enum logic [1:0] {
    PC_PLUS4_F  = 2'b00,
    PC_PRED_F   = 2'b01,
    PC_PLUS4_E  = 2'b10,
    PC_TARGET_E = 2'b11
  } pc_src_t;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // The tag field keeps the whole word address pc[31:2]. The index bits inside
  // it always match the slot they live in, so comparing pc[31:2] is the same
  // as comparing pc[31:IDX_W+2], and the layout stays independent of IDX_W.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

  localparam btb_entry_t BTB_ENTRY_RESET = '{
    valid:  1'b0,
    tag:    30'd0,
    target: 32'd0,
    ctr:    CTR_WNT
  };

endpackage

// File: rtl/sat_counter_2b.sv
// rtl/sat_counter_2b.sv - 2-bit saturating counter next-state function
// Ports: ctr_i current counter, taken_i resolved outcome,
//        ctr_next_o counter after training (saturates at 00 and 11).
module sat_counter_2b
  import branch_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_next_o
);

  always_comb begin
    ctr_next_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_ST) ctr_next_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != CTR_SNT) ctr_next_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB-based dynamic branch predictor and resolver
// Ports: clk_i/reset_i (sync, active-high); pc_f_i fetch PC lookup;
//        branch_op_e_i/taken_e_i/pc_e_i/pc_target_e_i/pred_taken_e_i/
//        pred_pc_target_e_i execute-stage resolution inputs;
//        pc_src_o next-PC select, pred_pc_target_f_o/pred_taken_f_o fetch
//        prediction, mispredict_o flush request, branch_cnt_o/mispredict_cnt_o
//        saturating statistics.
module branch_predictor
  import branch_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(BTB_ENTRIES)
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] pc_f_i,
  input  logic        branch_op_e_i,
  input  logic        taken_e_i,
  input  logic [31:0] pc_e_i,
  input  logic [31:0] pc_target_e_i,
  input  logic        pred_taken_e_i,
  input  logic [31:0] pred_pc_target_e_i,
  output logic [1:0]  pc_src_o,
  output logic [31:0] pred_pc_target_f_o,
  output logic        pred_taken_f_o,
  output logic        mispredict_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispredict_cnt_o
);

  btb_entry_t btb_q [BTB_ENTRIES];
  btb_entry_t btb_d [BTB_ENTRIES];
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  logic [IDX_W-1:0] idx_f, idx_e;
  logic             hit_f, hit_e;
  logic             mispredict;
  logic [1:0]       ctr_next_e;
  pc_src_t          pc_src;

  // Byte-offset bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_f_i[1:0], pc_e_i[1:0]};

  assign idx_f = pc_f_i[IDX_W+1:2];
  assign idx_e = pc_e_i[IDX_W+1:2];

  // Fetch lookup reads the registered table only, so a same-cycle update at
  // the same index is not bypassed. Reset forces a miss.
  assign hit_f = btb_q[idx_f].valid && (btb_q[idx_f].tag == pc_f_i[31:2]) && !reset_i;
  assign hit_e = btb_q[idx_e].valid && (btb_q[idx_e].tag == pc_e_i[31:2]);

  assign pred_taken_f_o     = hit_f && btb_q[idx_f].ctr[1];
  assign pred_pc_target_f_o = hit_f ? btb_q[idx_f].target : 32'd0;

  // A target mismatch only matters when both prediction and outcome are taken.
  assign mispredict = branch_op_e_i && !reset_i &&
                      ((pred_taken_e_i != taken_e_i) ||
                       (taken_e_i && (pred_pc_target_e_i != pc_target_e_i)));
  assign mispredict_o = mispredict;

  // Execute-stage redirect outranks any fetch-stage prediction.
  always_comb begin
    pc_src = PC_PLUS4_F;
    if (mispredict) begin
      pc_src = taken_e_i ? PC_TARGET_E : PC_PLUS4_E;
    end else if (pred_taken_f_o) begin
      pc_src = PC_PRED_F;
    end
  end
  assign pc_src_o = pc_src;

  sat_counter_2b u_sat_counter (
    .ctr_i      (btb_q[idx_e].ctr),
    .taken_i    (taken_e_i),
    .ctr_next_o (ctr_next_e)
  );

  always_comb begin
    btb_d = btb_q;
    if (branch_op_e_i) begin
      if (hit_e) begin
        btb_d[idx_e].ctr = ctr_next_e;
        if (taken_e_i) btb_d[idx_e].target = pc_target_e_i;
      end else if (taken_e_i) begin
        // Allocation evicts whatever occupied the slot.
        btb_d[idx_e] = '{valid: 1'b1, tag: pc_e_i[31:2], target: pc_target_e_i, ctr: CTR_WT};
      end
    end
  end

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (branch_op_e_i && (branch_cnt_q != 32'hFFFF_FFFF)) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (mispredict && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
      mispredict_cnt_d = mispredict_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_q[i] <= BTB_ENTRY_RESET;
      branch_cnt_q     <= 32'd0;
      mispredict_cnt_q <= 32'd0;
    end else begin
      btb_q            <= btb_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule
